serial_incrementer_seq: RTL
===========================

Name: serial_incrementer_seq

Overview:
Multi-cycle sequencer that adds a carry-in (0 or 1) to a WIDTH-bit operand one 4-bit slice per clock. It starts at the least significant nibble and drives a 4-bit incrementer slice. It exits early once the carry dies, because the upper nibbles then pass through unchanged. It sits between the ALU operand register (upstream, valid/ready) and the ALU result mux (downstream, valid/ready).

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NIB, derived WIDTH/4, number of 4-bit slices; not user-settable
CNT_W, derived max(1,$clog2(NIB)), width of the slice index counter

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream operand valid
in_ready  output  1  block accepts an operand (IDLE only)
in_data  input  WIDTH  operand
in_cin  input  1  carry-in: 1 = increment, 0 = pass-through
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  result
out_carry  output  1  carry-out of the MSB slice (overflow)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0, idx=0, carry=0, work reg=0.
- Reset mid-operation: all state is cleared immediately and any in-flight operand is discarded, with no output.
- FSM IDLE -> RUN:
  - Handshake in_valid&&in_ready loads work<=in_data, carry<=in_cin, idx<=0.
  - in_ready=1 only in IDLE; in_data and in_cin are ignored in every other state.
- FSM RUN (one slice per cycle):
  - work[idx*4+:4] <= slice + carry; carry <= (slice==4'hF)&&carry.
  - The next carry is computed by the slice sub-module.
  - If the new carry==0 or idx==NIB-1: go to DONE.
  - Otherwise idx<=idx+1 and stay in RUN.
- FSM DONE:
  - out_valid=1; out_data=work; out_carry=carry.
  - Outputs are held stable until out_ready. On out_valid&&out_ready, go to IDLE.
  - The input accepts no new operand in the same cycle (no overlap).
- Latency:
  - Accept edge to out_valid: 1 + k cycles.
  - k = index of the lowest non-F nibble + 1, capped at NIB.
  - in_cin=0 gives k=1 and out_data=in_data.
- Overflow:
  - All nibbles F with in_cin=1 gives k=NIB, out_data=0, out_carry=1.
  - out_carry=0 in every other case.
- Arithmetic: modulo 2^WIDTH. Unprocessed upper nibbles retain their loaded value.
- Backpressure: out_ready low in DONE stalls indefinitely. in_ready stays 0 during the stall.
- Simultaneous events: out_ready while in RUN has no effect. in_valid while not in IDLE is not accepted and is not lost, because upstream holds it.
- Boundary at WIDTH=4:
  - NIB=1, so DONE is always reached after exactly one RUN cycle.
  - The idx counter is 1 bit and constant 0.

Decomposition:
- Shared package alu_pkg:
  - state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - SLICE_W=4.
- One natural sub-module: incr_nibble_slice.
  - Combinational: inputs nib[3:0], cin; outputs sum[3:0], cout.
  - Instanced once and muxed by idx.
- The top level holds the FSM, idx counter, carry flop and work register.

Test Plan:
- WIDTH=16, in_data=16'h1234, cin=1, out_ready=1 -> out_data=16'h1235, out_carry=0, out_valid 2 cycles after accept.
- in_data=16'h12FF, cin=1 -> out_data=16'h1300, out_carry=0, k=3, out_valid 4 cycles after accept.
- in_data=16'hFFFF, cin=1 -> out_data=16'h0000, out_carry=1, out_valid 5 cycles after accept; in_ready=0 throughout.
- in_data=16'hABCD, cin=0 -> out_data=16'hABCD, out_carry=0, out_valid 2 cycles after accept.
- Backpressure case:
  - Stimulus: 16'h00FF with cin=1; hold out_ready=0 for 5 cycles in DONE; change in_data/in_valid meanwhile.
  - Response: out_data stays 16'h0100 and in_ready stays 0; returns to IDLE one cycle after out_ready=1.
- Reset case: assert rst_n=0 during RUN of 16'hFFFF -> out_valid=0, in_ready=1 immediately; next operand 16'h0001 gives 16'h0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the serial incrementer: FSM state codes and slice width.
package alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SLICE_W = 4;

endpackage

// File: rtl/incr_nibble_slice.sv
// One 4-bit incrementer slice: adds a single carry bit to a nibble.
module incr_nibble_slice
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] i_nib,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [SLICE_W:0] w_full;

    assign w_full = {1'b0, i_nib} + {{SLICE_W{1'b0}}, i_cin};
    assign o_sum  = w_full[SLICE_W-1:0];
    assign o_cout = w_full[SLICE_W];

endmodule

// File: rtl/serial_incrementer_seq.sv
// Adds a carry-in to a WIDTH-bit operand one nibble per clock, stopping as soon
// as the carry dies. valid/ready on both sides, one operand in flight at a time.
module serial_incrementer_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic [1:0]       o_dbg_state
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [CNT_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_work;
    logic [SLICE_W-1:0] w_nib;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;
    logic               w_last;
    logic               w_accept;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds its data stable until that edge.
    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_idx == CNT_W'(NIB - 1));

    always_comb begin
        w_nib = '0;
        for (int n = 0; n < NIB; n++) begin
            if (r_idx == CNT_W'(n)) begin
                w_nib = r_work[n*SLICE_W +: SLICE_W];
            end
        end
    end

    incr_nibble_slice u_slice (
        .i_nib  (w_nib),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next_state = ST_RUN;
            ST_RUN:  if (!w_cout || w_last) w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == ST_IDLE);
        out_valid   = (r_state == ST_DONE);
        out_data    = (r_state == ST_DONE) ? r_work : '0;
        out_carry   = (r_state == ST_DONE) ? r_carry : 1'b0;
        o_dbg_state = r_state;
    end

    // Upper nibbles beyond the point where the carry died keep their loaded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_work  <= in_data;
            r_carry <= in_cin;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            for (int n = 0; n < NIB; n++) begin
                if (r_idx == CNT_W'(n)) begin
                    r_work[n*SLICE_W +: SLICE_W] <= w_sum;
                end
            end
            r_carry <= w_cout;
            if (w_cout && !w_last) begin
                r_idx <= r_idx + CNT_W'(1);
            end
        end
    end

endmodule
